// File: rtl/dct_pkg.sv
// Shared types and constants for the DCT vector-rotation frame sequencer.
package dct_pkg;

  localparam int unsigned N_MAX     = 2048;
  localparam int unsigned PTS_W     = 12;
  localparam int unsigned NUM_LEGAL = 7;

  localparam logic [NUM_LEGAL-1:0][PTS_W-1:0] LEGAL_PTS = {
    12'd2048, 12'd1024, 12'd512, 12'd256, 12'd128, 12'd64, 12'd32
  };

  typedef enum logic [1:0] {IDLE, LOAD, RUN, GAP} state_t;

  function automatic logic is_legal_pts(input logic [PTS_W-1:0] n);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < NUM_LEGAL; i++)
      if (n == LEGAL_PTS[i]) ok = 1'b1;
    return ok;
  endfunction

endpackage

// File: rtl/dct_vecrot_seq_if.sv
// Request, coefficient-generator, F-buffer address and rotation-marker signals.
interface dct_vecrot_seq_if #(parameter int wIdx = 11);
  logic             cfg_valid;
  logic [11:0]      cfg_fftpts;
  logic             cfg_ready;
  logic [11:0]      coeff_fftpts;
  logic             coeff_sink_valid;
  logic [wIdx-1:0]  rd_addr_a;
  logic [wIdx-1:0]  rd_addr_b;
  logic             rot_valid;
  logic             rot_sop;
  logic             rot_eop;
  logic             busy;
  logic             frame_done;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_fftpts,
    input  cfg_ready, coeff_fftpts, coeff_sink_valid, rd_addr_a, rd_addr_b,
           rot_valid, rot_sop, rot_eop, busy, frame_done, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_fftpts,
    output cfg_ready, coeff_fftpts, coeff_sink_valid, rd_addr_a, rd_addr_b,
           rot_valid, rot_sop, rot_eop, busy, frame_done, cfg_err
  );
endinterface

// File: rtl/dct_delay_line.sv
// Fixed-depth shift register with async active-low clear.
module dct_delay_line #(
  parameter int DEPTH = 1,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/dct_vecrot_seq.sv
// Frame sequencer: programs the coefficient generator, bursts sink_valid for N
// cycles, emits mirrored F-buffer addresses and latency-aligned rotation markers.
module dct_vecrot_seq
  import dct_pkg::*;
#(
  parameter int COEFF_LAT = 1,
  parameter int wIdx      = 11,
  parameter int MIN_GAP   = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  dct_vecrot_seq_if.slave bus
);

  localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

  state_t             state_q, state_d;
  logic [PTS_W-1:0]   pts_q, pts_d;
  logic [wIdx-1:0]    idx_q, idx_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic               err_q, err_d;

  logic               run;
  logic               first, last;
  logic [PTS_W-1:0]   idx_ext;
  logic [PTS_W-1:0]   mirror;
  logic [2:0]         mark_d, mark_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pts_q   <= PTS_W'(N_MAX);
      idx_q   <= '0;
      gap_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pts_q   <= pts_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      err_q   <= err_d;
    end
  end

  assign run     = (state_q == RUN);
  assign idx_ext = PTS_W'(idx_q);
  assign first   = (idx_ext == '0);
  assign last    = (idx_ext == pts_q - 12'd1);
  // N is a power of two, so masking with N-1 folds N-0 back onto address 0.
  assign mirror  = (pts_q - idx_ext) & (pts_q - 12'd1);

  always_comb begin
    state_d = state_q;
    pts_d   = pts_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.cfg_valid) begin
          if (is_legal_pts(bus.cfg_fftpts)) begin
            pts_d   = bus.cfg_fftpts;
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        idx_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        idx_d = idx_q + 1'b1;
        if (last) begin
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GW'(MIN_GAP - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Markers travel with sink_valid through the generator's latency.
  assign mark_d = {run & last, run & first, run};

  dct_delay_line #(.DEPTH(COEFF_LAT), .W(3)) u_mark_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (mark_d),
    .q_o   (mark_q)
  );

  assign bus.cfg_ready        = (state_q == IDLE);
  assign bus.coeff_fftpts     = pts_q;
  assign bus.coeff_sink_valid = run;
  assign bus.rd_addr_a        = run ? idx_q : '0;
  assign bus.rd_addr_b        = run ? wIdx'(mirror) : '0;
  assign bus.rot_valid        = mark_q[0];
  assign bus.rot_sop          = mark_q[1];
  assign bus.rot_eop          = mark_q[2];
  assign bus.frame_done       = mark_q[2];
  assign bus.busy             = (state_q != IDLE);
  assign bus.cfg_err          = err_q;

endmodule

// File: tb/tb_dct_vecrot_seq.sv
// Directed bench for dct_vecrot_seq: frame table plus back-to-back, held-request,
// mid-frame reset and COEFF_LAT=3 alignment sequences.
`timescale 1ns/1ps
module tb_dct_vecrot_seq;

  localparam int MG = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   hs_q[$];

  dct_vecrot_seq_if #(.wIdx(11)) b1();
  dct_vecrot_seq_if #(.wIdx(11)) b3();

  dct_vecrot_seq #(.COEFF_LAT(1), .wIdx(11), .MIN_GAP(MG)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );
  dct_vecrot_seq #(.COEFF_LAT(3), .wIdx(11), .MIN_GAP(MG)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) if (b1.frame_done) done_cnt++;
  always @(negedge clk) if (b1.cfg_valid && b1.cfg_ready) hs_q.push_back(cyc);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [11:0] n;
    bit          legal;
    logic [11:0] exp_pts;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int bound);
    int g = 0;
    while (b1.busy && g < bound) begin step(); g++; end
    chk("idle_wait", b1.busy, 0);
  endtask

  task automatic run_frame(input logic [11:0] n, input bit legal, input logic [11:0] exp_pts);
    int g = 0, k = 0, beat = 0, rises = 0;
    int sop_c = 0, sop_b = 0, eop_c = 0, eop_b = 0, done_c = 0, dmis = 0;
    int e = 0, sv = 0, bz = 0;
    bit prev = 1'b0;
    while (!b1.cfg_ready && g < 5000) begin step(); g++; end
    chk("ready_wait", b1.cfg_ready, 1);
    b1.cfg_valid = 1'b1; b1.cfg_fftpts = n;
    step();
    b1.cfg_valid = 1'b0;
    chk("fftpts", b1.coeff_fftpts, exp_pts);
    if (!legal) begin
      chk("err_pulse", b1.cfg_err, 1);
      chk("err_busy", b1.busy, 0);
      repeat (8) begin
        step();
        e += b1.cfg_err; sv += b1.coeff_sink_valid; bz += b1.busy;
      end
      chk("err_once", e, 0);
      chk("err_no_burst", sv, 0);
      chk("err_busy_hold", bz, 0);
      chk("err_fftpts_hold", b1.coeff_fftpts, exp_pts);
      return;
    end
    chk("load_busy", b1.busy, 1);
    chk("load_ready", b1.cfg_ready, 0);
    chk("load_sink", b1.coeff_sink_valid, 0);
    for (int c = 0; c < n + MG + 4; c++) begin
      step();
      if (b1.coeff_sink_valid) begin
        chk("addr_a", b1.rd_addr_a, k);
        chk("addr_b", b1.rd_addr_b, (k == 0) ? 0 : int'(n) - k);
        if (!prev) rises++;
        k++;
      end
      prev = b1.coeff_sink_valid;
      if (b1.rot_valid) beat++;
      if (b1.rot_sop) begin sop_c++; sop_b = beat; end
      if (b1.rot_eop) begin eop_c++; eop_b = beat; end
      if (b1.frame_done !== b1.rot_eop) dmis++;
      done_c += b1.frame_done;
    end
    chk("sink_count", k, n);
    chk("sink_bursts", rises, 1);
    chk("rot_beats", beat, n);
    chk("sop_count", sop_c, 1);
    chk("sop_beat", sop_b, 1);
    chk("eop_count", eop_c, 1);
    chk("eop_beat", eop_b, n);
    chk("done_count", done_c, 1);
    chk("done_eq_eop", dmis, 0);
    chk("end_ready", b1.cfg_ready, 1);
    chk("end_fftpts", b1.coeff_fftpts, exp_pts);
  endtask

  initial begin
    vec_t tbl[7];
    int g, seen, low, d0, fsv, frv, lsv, eat, bt;

    tbl[0] = '{12'd32,   1'b1, 12'd32};
    tbl[1] = '{12'd100,  1'b0, 12'd32};
    tbl[2] = '{12'd64,   1'b1, 12'd64};
    tbl[3] = '{12'd0,    1'b0, 12'd64};
    tbl[4] = '{12'd2047, 1'b0, 12'd64};
    tbl[5] = '{12'd256,  1'b1, 12'd256};
    tbl[6] = '{12'd2048, 1'b1, 12'd2048};

    b1.cfg_valid = 1'b0; b1.cfg_fftpts = '0;
    b3.cfg_valid = 1'b0; b3.cfg_fftpts = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", b1.cfg_ready, 1);
    chk("rst_fftpts", b1.coeff_fftpts, 2048);
    chk("rst_busy", b1.busy, 0);
    chk("rst_sink", b1.coeff_sink_valid, 0);
    chk("rst_rot_valid", b1.rot_valid, 0);
    chk("rst_err", b1.cfg_err, 0);
    chk("rst_addr_b", b1.rd_addr_b, 0);
    #1 rst_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) run_frame(tbl[i].n, tbl[i].legal, tbl[i].exp_pts);

    // N=64 then N=2048 with request held: handshake spacing and idle gap
    hs_q.delete();
    b1.cfg_valid = 1'b1; b1.cfg_fftpts = 12'd64;
    step();
    b1.cfg_fftpts = 12'd2048;
    g = 0; seen = 0; low = 0;
    while (hs_q.size() < 2 && g < 300) begin
      step(); g++;
      if (b1.coeff_sink_valid) seen = 1;
      else if (seen != 0) low++;
    end
    b1.cfg_valid = 1'b0;
    chk("b2b_hs_count", hs_q.size(), 2);
    if (hs_q.size() >= 2) chk("b2b_spacing", hs_q[1] - hs_q[0], 64 + 2 + MG);
    chk("b2b_gap", int'(low >= MG), 1);
    wait_idle(3000);
    chk("b2b_fftpts", b1.coeff_fftpts, 2048);

    // Request held through N=128 frames: one accept per frame
    step();
    hs_q.delete();
    b1.cfg_valid = 1'b1; b1.cfg_fftpts = 12'd128;
    repeat (300) step();
    b1.cfg_valid = 1'b0;
    chk("hold_hs_count", hs_q.size(), 3);
    if (hs_q.size() >= 3) begin
      chk("hold_spacing0", hs_q[1] - hs_q[0], 128 + 2 + MG);
      chk("hold_spacing1", hs_q[2] - hs_q[1], 128 + 2 + MG);
    end
    wait_idle(500);

    // Mid-frame reset at idx=500 of N=1024
    step();
    b1.cfg_valid = 1'b1; b1.cfg_fftpts = 12'd1024;
    step();
    b1.cfg_valid = 1'b0;
    g = 0;
    while (!(b1.coeff_sink_valid && b1.rd_addr_a == 11'd500) && g < 2000) begin step(); g++; end
    chk("rst_mid_reached", b1.rd_addr_a, 500);
    chk("rst_mid_rot_before", b1.rot_valid, 1);
    d0 = done_cnt;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_sink", b1.coeff_sink_valid, 0);
    chk("rst_mid_rot", b1.rot_valid, 0);
    chk("rst_mid_busy", b1.busy, 0);
    chk("rst_mid_ready", b1.cfg_ready, 1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) step();
    chk("rst_mid_no_done", done_cnt - d0, 0);
    chk("rst_mid_ready_after", b1.cfg_ready, 1);
    chk("rst_mid_fftpts", b1.coeff_fftpts, 2048);
    chk("rst_mid_idle", b1.busy, 0);

    // COEFF_LAT=3 alignment with N=256
    b3.cfg_valid = 1'b1; b3.cfg_fftpts = 12'd256;
    step();
    b3.cfg_valid = 1'b0;
    fsv = -1; frv = -1; lsv = -1; eat = -1; bt = 0;
    for (int c = 0; c < 256 + 12; c++) begin
      step();
      if (b3.coeff_sink_valid) begin
        if (fsv < 0) fsv = c;
        lsv = c;
      end
      if (b3.rot_valid) begin
        if (frv < 0) frv = c;
        bt++;
      end
      if (b3.rot_eop) eat = c;
    end
    chk("lat3_fftpts", b3.coeff_fftpts, 256);
    chk("lat3_valid_delay", frv - fsv, 3);
    chk("lat3_eop_delay", eat - lsv, 3);
    chk("lat3_beats", bt, 256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dct_vecrot_seq.md
Name: dct_vecrot_seq

Overview:
- Frame-level sequencer for the DCT vector-rotation stage.
- Accepts one DCT frame request (length N) per handshake, programs the coefficient ROM generator's point-size input and drives its sink_valid burst for exactly N cycles.
- Generates the paired F-buffer read addresses for each output index: F(k) and its mirror F(N+2-k).
- Emits delay-aligned valid, sop and eop markers so the rotation multiplier sees coefficients and operands on the same cycle.

Parameters:
- COEFF_LAT, 1: clocks from coeff_sink_valid to coefficient available on the generator outputs.
- wIdx, 11: width of index and address outputs (N max 2048).
- MIN_GAP, 1: idle cycles forced between frames; must be ≥1 so the generator's address accumulator clears.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- cfg_valid  in  1  frame request
- cfg_fftpts  in  12  requested N
- cfg_ready  out  1  request accepted when cfg_valid & cfg_ready
- coeff_fftpts  out  12  point size to the coefficient generator
- coeff_sink_valid  out  1  sink_valid to the coefficient generator
- rd_addr_a  out  wIdx  F buffer address, k-1
- rd_addr_b  out  wIdx  F buffer address, (N-(k-1)) mod N
- rot_valid  out  1  coeff_sink_valid delayed COEFF_LAT
- rot_sop  out  1  first index of frame, aligned with rot_valid
- rot_eop  out  1  last index of frame, aligned with rot_valid
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse on the cycle rot_eop is asserted
- cfg_err  out  1  one-cycle pulse when an illegal N is rejected

Behaviour:
- Reset values: all outputs 0, except cfg_ready=1 and coeff_fftpts=2048. Reset applies immediately from any state, mid-frame included: pipeline flushed, no partial eop or frame_done emitted.
- Legal N values: 32, 64, 128, 256, 512, 1024, 2048.
- Illegal N: request still handshakes (cfg_ready high), cfg_err pulses the next cycle, state remains IDLE, coeff_fftpts unchanged.
- IDLE: cfg_ready=1. On an accepted legal request, latch N, drive coeff_fftpts=N, go to LOAD.
- LOAD: one cycle, cfg_ready=0. Lets the generator register its step from coeff_fftpts before valid rises. Go to RUN with idx=0.
- RUN:
  - coeff_sink_valid=1.
  - rd_addr_a=idx; rd_addr_b=(N-idx)&(N-1), so idx=0 gives 0.
  - idx increments each cycle; no stall is supported inside a frame.
  - On the cycle with idx=N-1, go to GAP.
- GAP: coeff_sink_valid=0 for MIN_GAP cycles, then IDLE. cfg_ready=0 throughout.
- Accept latency: earliest next accept is the cycle after GAP ends. Back-to-back frames are spaced N+2+MIN_GAP cycles apart from handshake to handshake.
- Alignment: rot_valid, rot_sop and rot_eop are RUN-phase valid/first/last, shifted through a COEFF_LAT-deep register chain.
  - frame_done equals rot_eop.
  - The chain keeps shifting in GAP and IDLE, so tail markers always drain.
- rd_addr_a and rd_addr_b are not delayed: the F buffer read latency is matched to COEFF_LAT by the consumer.
- coeff_fftpts is stable from LOAD until the next accepted legal request.
- cfg_valid is ignored outside IDLE; the requester must hold it until the handshake.

Decomposition:
- Shared package dct_pkg holds:
  - the legal-N list and an is_legal_pts function;
  - N_MAX=2048;
  - the state enum {IDLE, LOAD, RUN, GAP}.
- One sub-module: dct_delay_line, a parameterised-depth shift register with async reset, used for the valid/sop/eop alignment.

Test Plan:
- Reset, then request N=32 → coeff_fftpts=32 one cycle after the handshake; coeff_sink_valid high for exactly 32 cycles; rd_addr_a 0..31; rd_addr_b 0,31,30..1; rot_sop/rot_eop on rot_valid beats 1 and 32.
- Request N=2048 immediately after an N=64 frame → coeff_sink_valid low for ≥1 cycle between bursts; next handshake occurs exactly 64+2+MIN_GAP cycles after the first.
- Request cfg_fftpts=100 → cfg_err pulses once, busy stays 0, coeff_fftpts keeps its previous value, no valid burst.
- Hold cfg_valid high through a whole N=128 frame → exactly one accept per frame; the second accept occurs only after GAP.
- Assert rst_n low at idx=500 of an N=1024 frame → all valids drop asynchronously; no frame_done; cfg_ready=1 after release.
- COEFF_LAT=3 build with N=256 → rot_valid rises exactly 3 cycles after coeff_sink_valid; rot_eop 3 cycles after the last RUN cycle.
